// File: rtl/dmem_lsu.sv
// Data-memory stage: byte-addressed little-endian word array with lane-masked
// stores, extended combinational loads, sticky fault capture and access counters.
module dmem_lsu #(
  parameter int DEPTH_WORDS = 256,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       data_w,
  output logic [31:0]       data_o,
  output logic              fault_o,
  output logic              err_o,
  output logic [31:0]       err_addr_o,
  output logic [CNT_W-1:0]  load_cnt_o,
  output logic [CNT_W-1:0]  store_cnt_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word;
  logic             ld_code_ok;
  logic             st_code_ok;
  logic             misaligned;
  logic             in_range;
  logic             fault;
  logic             legal_ld;
  logic             legal_st;

  // Select the addressed lane of a word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replicate the store data across lanes and merge only the enabled bytes.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [3:0]  be;
    logic [31:0] rep;
    logic [31:0] r;
    case (f3[1:0])
      2'b00: begin
        be  = 4'b0001 << off;
        rep = {4{wd[7:0]}};
      end
      2'b01: begin
        be  = off[1] ? 4'b1100 : 4'b0011;
        rep = {2{wd[15:0]}};
      end
      default: begin
        be  = 4'b1111;
        rep = wd;
      end
    endcase
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = rep[8*b +: 8];
    end
    return r;
  endfunction

  assign idx     = addr[IDX_W+1:2];
  assign rd_word = mem[idx];

  always_comb begin
    ld_code_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
    st_code_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    in_range   = (addr[31:IDX_W+2] == '0);
    fault      = (mem_read && mem_write) ||
                 (mem_read && !ld_code_ok) ||
                 (mem_write && !st_code_ok) ||
                 ((mem_read || mem_write) && (misaligned || !in_range));
    legal_ld   = mem_read && !fault;
    legal_st   = mem_write && !fault;
  end

  // Outputs are forced quiet while reset is held, whatever the inputs do.
  assign data_o  = (legal_ld && !rst) ? load_extend(rd_word, funct3, addr[1:0]) : 32'd0;
  assign fault_o = fault && !rst;

  // Array: cleared by reset, committed on the edge ending the store cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    end else if (legal_st) begin
      mem[idx] <= store_merge(rd_word, data_w, funct3, addr[1:0]);
    end
  end

  // Sticky first-fault record and wrapping access counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o       <= 1'b0;
      err_addr_o  <= 32'd0;
      load_cnt_o  <= '0;
      store_cnt_o <= '0;
    end else begin
      if (fault_o && !err_o) begin
        err_o      <= 1'b1;
        err_addr_o <= addr;
      end
      if (legal_ld) load_cnt_o  <= load_cnt_o + CNT_W'(1);
      if (legal_st) store_cnt_o <= store_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed scenarios plus randomized traffic checked
// against a byte-array reference model.
module tb_dmem_lsu;

  localparam int DEPTH = 256;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_read;
  logic          mem_write;
  logic [2:0]    funct3;
  logic [31:0]   addr;
  logic [31:0]   data_w;
  logic [31:0]   data_o;
  logic          fault_o;
  logic          err_o;
  logic [31:0]   err_addr_o;
  logic [CW-1:0] load_cnt_o;
  logic [CW-1:0] store_cnt_o;

  dmem_lsu #(.DEPTH_WORDS(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .data_w(data_w), .data_o(data_o),
    .fault_o(fault_o), .err_o(err_o), .err_addr_o(err_addr_o),
    .load_cnt_o(load_cnt_o), .store_cnt_o(store_cnt_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mb [DEPTH*4];
  int          m_lcnt;
  int          m_scnt;
  logic        m_err;
  logic [31:0] m_eaddr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int m_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic m_fault(input logic mr, input logic mw,
                                   input logic [2:0] f3, input logic [31:0] a);
    int s;
    if (!mr && !mw) return 1'b0;
    if (mr && mw) return 1'b1;
    if (mr && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (mw && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
    s = m_size(f3);
    if ((a % s) != 0) return 1'b1;
    if ((a / 4) >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    int s;
    logic [31:0] v;
    s = m_size(f3);
    v = 32'd0;
    for (int k = 0; k < s; k++) v = v | (32'(mb[int'(a) + k]) << (8 * k));
    if (!f3[2] && s < 4 && v[8*s-1]) v = v | (32'hFFFF_FFFF << (8 * s));
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'h00;
    m_lcnt = 0; m_scnt = 0; m_err = 1'b0; m_eaddr = 32'd0;
  endtask

  task automatic model_edge(input logic mr, input logic mw,
                            input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic f;
    f = m_fault(mr, mw, f3, a);
    if (f && !m_err) begin
      m_err = 1'b1;
      m_eaddr = a;
    end
    if (mr && !f) m_lcnt = (m_lcnt + 1) % (1 << CW);
    if (mw && !f) begin
      for (int k = 0; k < m_size(f3); k++) mb[int'(a) + k] = wd[8*k +: 8];
      m_scnt = (m_scnt + 1) % (1 << CW);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_err"},   {31'd0, err_o}, {31'd0, m_err});
    check({tag, "_eaddr"}, err_addr_o, m_eaddr);
    check({tag, "_lcnt"},  32'(load_cnt_o), 32'(m_lcnt));
    check({tag, "_scnt"},  32'(store_cnt_o), 32'(m_scnt));
  endtask

  // One access cycle: drive after negedge, check combinational outputs,
  // let the edge commit, then check registered state.
  task automatic cycle(input string tag, input logic mr, input logic mw,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] dobs, output logic fobs);
    logic f;
    @(negedge clk);
    mem_read = mr; mem_write = mw; funct3 = f3; addr = a; data_w = wd;
    #1;
    f = m_fault(mr, mw, f3, a);
    check({tag, "_data"}, data_o, (mr && !f) ? m_load(f3, a) : 32'd0);
    check({tag, "_fault"}, {31'd0, fault_o}, {31'd0, f});
    dobs = data_o;
    fobs = fault_o;
    @(posedge clk);
    model_edge(mr, mw, f3, a, wd);
    #1;
    check_state(tag);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  logic [31:0] d;
  logic        fl;

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0; addr = 32'd0; data_w = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", data_o, 32'd0);
    check("rst_fault", {31'd0, fault_o}, 32'd0);
    check_state("rst");
    @(negedge clk); rst = 1'b0;

    // Alignment and extension
    cycle("sw10", 0, 1, 3'b010, 32'h10, 32'h8765_43A1, d, fl);
    cycle("lb10", 1, 0, 3'b000, 32'h10, 32'h0, d, fl);  check("lb10_k", d, 32'hFFFF_FFA1);
    cycle("lbu10", 1, 0, 3'b100, 32'h10, 32'h0, d, fl); check("lbu10_k", d, 32'h0000_00A1);
    cycle("lh10", 1, 0, 3'b001, 32'h10, 32'h0, d, fl);  check("lh10_k", d, 32'h0000_43A1);
    cycle("lh12", 1, 0, 3'b001, 32'h12, 32'h0, d, fl);  check("lh12_k", d, 32'hFFFF_8765);
    cycle("lhu12", 1, 0, 3'b101, 32'h12, 32'h0, d, fl); check("lhu12_k", d, 32'h0000_8765);
    cycle("lw10", 1, 0, 3'b010, 32'h10, 32'h0, d, fl);  check("lw10_k", d, 32'h8765_43A1);

    // Lane merge
    cycle("sw20", 0, 1, 3'b010, 32'h20, 32'h0, d, fl);
    cycle("sb23", 0, 1, 3'b000, 32'h23, 32'hFFFF_FF5A, d, fl);
    cycle("sh20", 0, 1, 3'b001, 32'h20, 32'h1234_BEEF, d, fl);
    cycle("lw20", 1, 0, 3'b010, 32'h20, 32'h0, d, fl);  check("lw20_k", d, 32'h5A00_BEEF);

    // Faults and sticky capture
    cycle("lw21", 1, 0, 3'b010, 32'h21, 32'h0, d, fl);
    check("lw21_d", d, 32'd0); check("lw21_f", {31'd0, fl}, 32'd1);
    check("lw21_err", {31'd0, err_o}, 32'd1); check("lw21_ea", err_addr_o, 32'h21);
    cycle("sh401", 0, 1, 3'b001, 32'h401, 32'hFFFF_FFFF, d, fl);
    check("sh401_ea", err_addr_o, 32'h21);
    cycle("rw20", 1, 1, 3'b010, 32'h20, 32'h0, d, fl); check("rw20_f", {31'd0, fl}, 32'd1);
    cycle("lw20b", 1, 0, 3'b010, 32'h20, 32'h0, d, fl); check("lw20b_k", d, 32'h5A00_BEEF);

    // Read of the word being written sees the old contents until the edge
    cycle("sw30a", 0, 1, 3'b010, 32'h30, 32'h1111_1111, d, fl);
    @(negedge clk);
    mem_write = 1'b1; funct3 = 3'b010; addr = 32'h30; data_w = 32'h2222_2222;
    #1; mem_write = 1'b0; mem_read = 1'b1;
    #1; check("rdw_old", data_o, 32'h1111_1111);
    mem_read = 1'b0; mem_write = 1'b1;
    #1; check("rdw_fault", {31'd0, fault_o}, 32'd0);
    @(posedge clk);
    model_edge(1'b0, 1'b1, 3'b010, 32'h30, 32'h2222_2222);
    #1; mem_write = 1'b0;
    cycle("lw30", 1, 0, 3'b010, 32'h30, 32'h0, d, fl); check("lw30_k", d, 32'h2222_2222);
    cycle("lb32", 1, 0, 3'b000, 32'h32, 32'h0, d, fl); check("lb32_k", d, 32'h0000_0022);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH*4 - 1));
      cycle("rnd", op[0], op[1], 3'($urandom_range(0, 7)), a, $urandom, d, fl);
    end

    // Asynchronous reset in the middle of a store cycle
    @(negedge clk);
    mem_write = 1'b1; funct3 = 3'b010; addr = 32'h40; data_w = 32'hDEAD_BEEF;
    #2 rst = 1'b1;
    #1;
    check("arst_data", data_o, 32'd0);
    check("arst_fault", {31'd0, fault_o}, 32'd0);
    model_reset();
    check_state("arst");
    mem_write = 1'b0; mem_read = 1'b1; addr = 32'h21;
    #1; check("arst_mis_f", {31'd0, fault_o}, 32'd0);
    @(posedge clk); #1;
    check("arst_hold_d", data_o, 32'd0);
    check_state("arst_hold");
    @(negedge clk); mem_read = 1'b0; rst = 1'b0;
    cycle("lw40", 1, 0, 3'b010, 32'h40, 32'h0, d, fl); check("lw40_k", d, 32'd0);
    cycle("lw10r", 1, 0, 3'b010, 32'h10, 32'h0, d, fl); check("lw10r_k", d, 32'd0);

    // Counter wrap: 17 legal loads from zero leave a 4-bit counter at 1
    @(negedge clk); rst = 1'b1; model_reset();
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 17; i++) cycle("wrap", 1, 0, 3'b010, 32'(4 * i), 32'h0, d, fl);
    check("wrap_k", 32'(load_cnt_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
